// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a single shared state register with a registered one-hot acknowledge.
// Optional lock/burst ownership is built only when REG_ARB_LOCK_EN is defined.
module reg_write_arbiter #(
   parameter int              width   = 1,
   parameter int              n       = 4,
   parameter logic [width-1:0] init   = '0,
   parameter int              maxlock = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [n-1:0]       req,
   input  logic [n-1:0]       lock,
   input  logic [n*width-1:0] data,
   output logic [n-1:0]       gnt,
   output logic [width-1:0]   out,
   output logic               busy
);

   localparam int             iw      = $clog2(n);
   localparam logic [iw-1:0]  ptr_rst = iw'(n - 1);

   logic [iw-1:0] ptr;
   logic [n-1:0]  cand;
   logic          rr_valid;
   logic [iw-1:0] rr_idx;
   logic          win_valid;
   logic [iw-1:0] win_idx;

   // First candidate after the last winner, wrapping modulo n.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rr_valid = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= n; k++) begin
         int j;
         j = (int'(ptr) + k) % n;
         if (!rr_valid && cand[j]) begin
            rr_valid = 1'b1;
            rr_idx   = j[iw-1:0];
         end
      end
   end

`ifdef REG_ARB_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state, state_nx;
   logic [iw-1:0] owner, owner_nx;
   logic [3:0]    cnt, cnt_nx;
   logic          owner_keep;
   logic [n-1:0]  excl;

   assign owner_keep = req[owner] & lock[owner];

   // The owner still wants the port but has used its budget: keep it out of this cycle's pick.
   always_comb begin
      excl = '0;
      if (state == LOCKED && owner_keep && cnt >= 4'(maxlock))
         excl[owner] = 1'b1;
   end

   assign cand = req & ~excl;

   always_comb begin
      state_nx  = state;
      owner_nx  = owner;
      cnt_nx    = cnt;
      win_valid = 1'b0;
      win_idx   = '0;
      if (state == LOCKED && owner_keep && cnt < 4'(maxlock)) begin
         win_valid = 1'b1;
         win_idx   = owner;
         cnt_nx    = cnt + 4'd1;
      end else begin
         state_nx  = IDLE;
         win_valid = rr_valid;
         win_idx   = rr_idx;
         if (rr_valid && lock[rr_idx]) begin
            state_nx = LOCKED;
            owner_nx = rr_idx;
            cnt_nx   = 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         cnt   <= cnt_nx;
      end
   end

   assign busy = (state == LOCKED);
`else
   logic unused_lock;

   assign unused_lock = ^lock;
   assign cand        = req;
   assign win_valid   = rr_valid;
   assign win_idx     = rr_idx;
   assign busy        = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= init;
         gnt <= '0;
         ptr <= ptr_rst;
      end else begin
         gnt <= '0;
         if (win_valid) begin
            out          <= data[int'(win_idx)*width +: width];
            gnt[win_idx] <= 1'b1;
            ptr          <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed table, lock sequence and randomized model comparison.
module tb_reg_write_arbiter;

   localparam int             W    = 8;
   localparam int             N    = 4;
   localparam int             ML   = 4;
   localparam logic [W-1:0]   INIT = 8'h5A;
`ifdef REG_ARB_LOCK_EN
   localparam bit             LOCK_EN = 1'b1;
`else
   localparam bit             LOCK_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, lock, gnt;
   logic [N*W-1:0] data;
   logic [W-1:0]   out;
   logic           busy;

   int vectors     = 0;
   int miscompares = 0;

   reg_write_arbiter #(.width(W), .n(N), .init(INIT), .maxlock(ML)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .data(data),
      .gnt(gnt), .out(out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [7:0]  out;
   } vec_t;

   vec_t tbl[15];

   // Reference model state
   logic [W-1:0] m_out;
   logic [N-1:0] m_gnt;
   logic         m_busy;
   int           m_ptr, m_owner, m_run;
   bit           m_locked;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of the arbiter's rules applied to the values presented this cycle.
   task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                             input logic [N*W-1:0] d);
      int w, skip;
      if (r) begin
         m_out = INIT; m_gnt = '0; m_ptr = N - 1; m_locked = 0; m_run = 0; m_busy = 0;
         return;
      end
      w = -1;
      skip = -1;
      if (LOCK_EN && m_locked && rq[m_owner] && lk[m_owner] && m_run < ML) begin
         w = m_owner;
         m_run++;
      end else begin
         if (LOCK_EN && m_locked && rq[m_owner] && lk[m_owner]) skip = m_owner;
         m_locked = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (w < 0 && c != skip && rq[c]) w = c;
         end
         if (w >= 0 && LOCK_EN && lk[w]) begin
            m_locked = 1; m_owner = w; m_run = 1;
         end
      end
      m_gnt = '0;
      if (w >= 0) begin
         m_out    = d[w*W +: W];
         m_gnt[w] = 1'b1;
         m_ptr    = w;
      end
      m_busy = m_locked;
   endtask

   initial begin
      logic [3:0] lk_gnt[6];
      logic       lk_busy[6];
      logic [7:0] lk_out[6];

      tbl[0]  = '{1'b1, 4'b0000, 32'h03020100, 4'b0000, 8'h5A};
      tbl[1]  = '{1'b1, 4'b1111, 32'h03020100, 4'b0000, 8'h5A};
      tbl[2]  = '{1'b0, 4'b1111, 32'h03020100, 4'b0001, 8'h00};
      tbl[3]  = '{1'b0, 4'b1111, 32'h03020100, 4'b0010, 8'h01};
      tbl[4]  = '{1'b0, 4'b1111, 32'h03020100, 4'b0100, 8'h02};
      tbl[5]  = '{1'b0, 4'b1111, 32'h03020100, 4'b1000, 8'h03};
      tbl[6]  = '{1'b0, 4'b1111, 32'h03020100, 4'b0001, 8'h00};
      tbl[7]  = '{1'b0, 4'b0100, 32'h03020100, 4'b0100, 8'h02};
      tbl[8]  = '{1'b0, 4'b0011, 32'h03020100, 4'b0001, 8'h00};
      tbl[9]  = '{1'b0, 4'b0011, 32'h03020100, 4'b0010, 8'h01};
      tbl[10] = '{1'b0, 4'b0000, 32'h03020100, 4'b0000, 8'h01};
      tbl[11] = '{1'b0, 4'b0000, 32'h03020100, 4'b0000, 8'h01};
      tbl[12] = '{1'b1, 4'b0100, 32'h03FF0100, 4'b0000, 8'h5A};
      tbl[13] = '{1'b0, 4'b0101, 32'h03FF0100, 4'b0001, 8'h00};
      tbl[14] = '{1'b0, 4'b0100, 32'h03FF0100, 4'b0100, 8'hFF};

      if (LOCK_EN) begin
         lk_gnt  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
         lk_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
         lk_out  = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h33, 8'h11};
      end else begin
         lk_gnt  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
         lk_busy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         lk_out  = '{8'h11, 8'h33, 8'h11, 8'h33, 8'h11, 8'h33};
      end

      rst = 1'b1; req = '0; lock = '0; data = '0;

      // Directed table: reset, fairness, sparse wrap, idle hold, reset mid-operation.
      for (int i = 0; i < 15; i++) begin
         rst = tbl[i].rst; req = tbl[i].req; lock = '0; data = tbl[i].data;
         tick();
         check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].out));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(0));
      end

      // Lock scenario: port 1 holds req+lock, port 3 holds req.
      rst = 1'b1; req = '0; lock = '0;
      tick();
      rst = 1'b0; req = 4'b1010; lock = 4'b0010; data = 32'h33221100;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("lock%0d_gnt", i), 32'(gnt), 32'(lk_gnt[i]));
         check($sformatf("lock%0d_busy", i), 32'(busy), 32'(lk_busy[i]));
         check($sformatf("lock%0d_out", i), 32'(out), 32'(lk_out[i]));
      end

      // Randomized traffic against the reference model, starting from reset.
      rst = 1'b1; req = '0; lock = '0; data = '0;
      model_step(rst, req, lock, data);
      tick();
      check("rand_reset_out", 32'(out), 32'(m_out));
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) begin
            req  = N'($urandom);
            lock = N'($urandom);
         end
         data = $urandom;
         model_step(rst, req, lock, data);
         tick();
         check($sformatf("rand%0d_gnt", c), 32'(gnt), 32'(m_gnt));
         check($sformatf("rand%0d_out", c), 32'(out), 32'(m_out));
         check($sformatf("rand%0d_busy", c), 32'(busy), 32'(m_busy));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
